sm83_irq_ctrl: RTL and testbench

SM83_IRQ_CTRL -- requirements
Module: sm83_irq_ctrl

---
 rtl/sm83_irq_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_sm83_irq_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/sm83_irq_ctrl.sv
// SM83 interrupt controller: IF/IE registers, IME with delayed EI, halt wake-up,
// and the five-cycle dispatch sequencer that pushes PC and jumps to the vector.
module sm83_irq_ctrl #(
  parameter logic [15:0] VEC_BASE = 16'h0040
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_boundary,
  input  logic        ei_exec,
  input  logic        di_exec,
  input  logic        reti_exec,
  input  logic        halt,
  input  logic [4:0]  irq_req,
  input  logic        if_wr,
  input  logic        ie_wr,
  input  logic [4:0]  wdata,
  output logic [4:0]  if_q,
  output logic [4:0]  ie_q,
  output logic        ime,
  output logic        wake,
  output logic        suppress_fetch,
  output logic        dispatch_active,
  output logic        sp_dec,
  output logic        pch_to_mem,
  output logic        pcl_to_mem,
  output logic        vec_to_pc,
  output logic [15:0] vector
);

  typedef enum logic [2:0] {
    IDLE,
    D_WAIT,
    D_SPDEC,
    D_PCH,
    D_PCL,
    D_JUMP
  } state_e;

  state_e      state_q, state_d;
  logic [4:0]  iflag_q, iflag_d;
  logic [4:0]  ienable_q, ienable_d;
  logic        ime_q, ime_d;
  logic        ei_delay_q, ei_delay_d;
  logic [15:0] vector_q, vector_d;
  logic        wake_cond_q;

  logic [4:0]  pending;
  logic        any_pending;
  logic        ctrl_ok;
  logic        ei_mature;
  logic        start;
  logic        win_valid;
  logic [2:0]  win_idx;
  logic [4:0]  clr_mask;

  assign pending     = ienable_q & iflag_q;
  assign any_pending = |pending;

  // Instruction-completion inputs are only honoured while the sequencer is idle.
  assign ctrl_ok   = (state_q == IDLE) && instr_boundary;
  assign ei_mature = ctrl_ok && ei_delay_q && !ei_exec;
  assign start     = ctrl_ok && (ime_q || ei_mature) && any_pending && !di_exec;

  // Lowest set bit wins; scanning downward lets the last hit be the lowest index.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = 3'd0;
    for (int i = 4; i >= 0; i--) begin
      if (pending[i]) begin
        win_valid = 1'b1;
        win_idx   = 3'(i);
      end
    end
  end

  assign clr_mask = (state_q == D_PCL && win_valid) ? (5'd1 << win_idx) : 5'd0;

  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    iflag_d    = ((if_wr ? wdata : iflag_q) & ~clr_mask) | irq_req;
    ienable_d  = ie_wr ? wdata : ienable_q;
    ime_d      = ime_q;
    ei_delay_d = ei_delay_q;
    vector_d   = vector_q;

    if (ctrl_ok) begin
      if (di_exec) begin
        ime_d      = 1'b0;
        ei_delay_d = 1'b0;
      end else if (start) begin
        ime_d      = 1'b0;
        ei_delay_d = ei_exec;
      end else begin
        if (reti_exec) ime_d = 1'b1;
        if (ei_exec) begin
          ei_delay_d = 1'b1;
        end else if (ei_delay_q) begin
          ime_d      = 1'b1;
          ei_delay_d = 1'b0;
        end
      end
    end

    if (state_q == D_PCL) begin
      vector_d = win_valid ? (VEC_BASE + {10'b0, win_idx, 3'b000}) : 16'h0000;
    end
  end

  always_comb begin
    state_d         = state_q;
    suppress_fetch  = 1'b0;
    dispatch_active = 1'b0;
    sp_dec          = 1'b0;
    pch_to_mem      = 1'b0;
    pcl_to_mem      = 1'b0;
    vec_to_pc       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d        = D_WAIT;
          suppress_fetch = 1'b1;
        end
      end
      D_WAIT: begin
        state_d         = D_SPDEC;
        suppress_fetch  = 1'b1;
        dispatch_active = 1'b1;
      end
      D_SPDEC: begin
        state_d         = D_PCH;
        suppress_fetch  = 1'b1;
        dispatch_active = 1'b1;
        sp_dec          = 1'b1;
      end
      D_PCH: begin
        state_d         = D_PCL;
        suppress_fetch  = 1'b1;
        dispatch_active = 1'b1;
        sp_dec          = 1'b1;
        pch_to_mem      = 1'b1;
      end
      D_PCL: begin
        state_d         = D_JUMP;
        suppress_fetch  = 1'b1;
        dispatch_active = 1'b1;
        pcl_to_mem      = 1'b1;
      end
      D_JUMP: begin
        state_d   = IDLE;
        vec_to_pc = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      iflag_q     <= 5'd0;
      ienable_q   <= 5'd0;
      ime_q       <= 1'b0;
      ei_delay_q  <= 1'b0;
      vector_q    <= 16'h0000;
      wake_cond_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      iflag_q     <= iflag_d;
      ienable_q   <= ienable_d;
      ime_q       <= ime_d;
      ei_delay_q  <= ei_delay_d;
      vector_q    <= vector_d;
      wake_cond_q <= halt & any_pending;
    end
  end

  // Wake fires on the rising edge of (halt && any_pending), independent of IME.
  assign wake   = halt & any_pending & ~wake_cond_q;
  assign if_q   = iflag_q;
  assign ie_q   = ienable_q;
  assign ime    = ime_q;
  assign vector = vector_q;

endmodule

// File: tb/tb_sm83_irq_ctrl.sv
// Cycle-by-cycle bench for sm83_irq_ctrl: each record drives one cycle of inputs
// and states every output expected before the following clock edge.
module tb_sm83_irq_ctrl;

  typedef struct {
    logic [4:0]  ic;    // {instr_boundary, ei_exec, di_exec, reti_exec, halt}
    logic [4:0]  irq;
    logic [1:0]  wr;    // {if_wr, ie_wr}
    logic [4:0]  wd;
    logic [4:0]  eif;
    logic [4:0]  eie;
    logic [7:0]  ectl;  // {ime, wake, suppress_fetch, dispatch_active, sp_dec, pch, pcl, vec_to_pc}
    logic [15:0] evec;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        instr_boundary, ei_exec, di_exec, reti_exec, halt;
  logic [4:0]  irq_req;
  logic        if_wr, ie_wr;
  logic [4:0]  wdata;
  logic [4:0]  if_q, ie_q;
  logic        ime, wake, suppress_fetch, dispatch_active;
  logic        sp_dec, pch_to_mem, pcl_to_mem, vec_to_pc;
  logic [15:0] vector;

  int   n_tests;
  int   n_fail;
  vec_t exp_q[$];
  vec_t tbl[53];

  sm83_irq_ctrl dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .instr_boundary  (instr_boundary),
    .ei_exec         (ei_exec),
    .di_exec         (di_exec),
    .reti_exec       (reti_exec),
    .halt            (halt),
    .irq_req         (irq_req),
    .if_wr           (if_wr),
    .ie_wr           (ie_wr),
    .wdata           (wdata),
    .if_q            (if_q),
    .ie_q            (ie_q),
    .ime             (ime),
    .wake            (wake),
    .suppress_fetch  (suppress_fetch),
    .dispatch_active (dispatch_active),
    .sp_dec          (sp_dec),
    .pch_to_mem      (pch_to_mem),
    .pcl_to_mem      (pcl_to_mem),
    .vec_to_pc       (vec_to_pc),
    .vector          (vector)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [4:0] ic, input logic [4:0] irq,
                              input logic [1:0] wr, input logic [4:0] wd,
                              input logic [4:0] eif, input logic [4:0] eie,
                              input logic [7:0] ectl, input logic [15:0] evec);
    vec_t v;
    v.ic = ic; v.irq = irq; v.wr = wr; v.wd = wd;
    v.eif = eif; v.eie = eie; v.ectl = ectl; v.evec = evec;
    return v;
  endfunction

  task automatic check(input string name, input int idx, input vec_t e);
    logic [33:0] act, want;
    act  = {if_q, ie_q, ime, wake, suppress_fetch, dispatch_active,
            sp_dec, pch_to_mem, pcl_to_mem, vec_to_pc, vector};
    want = {e.eif, e.eie, e.ectl, e.evec};
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s[%0d]: got if=%h ie=%h ctl=%b vec=%h, want if=%h ie=%h ctl=%b vec=%h",
               name, idx, act[33:29], act[28:24], act[23:16], act[15:0],
               e.eif, e.eie, e.ectl, e.evec);
    end
  endtask

  // Drive one cycle just after the rising edge; compare on the falling edge.
  task automatic step(input string name, input int idx, input vec_t v, input logic rst);
    vec_t e;
    @(posedge clk);
    #1;
    rst_n = rst;
    {instr_boundary, ei_exec, di_exec, reti_exec, halt} = v.ic;
    irq_req = v.irq;
    {if_wr, ie_wr} = v.wr;
    wdata = v.wd;
    exp_q.push_back(v);
    @(negedge clk);
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s[%0d]: scoreboard empty", name, idx);
    end else begin
      e = exp_q.pop_front();
      check(name, idx, e);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n = 1'b0;
    {instr_boundary, ei_exec, di_exec, reti_exec, halt} = 5'b0;
    irq_req = 5'd0; if_wr = 1'b0; ie_wr = 1'b0; wdata = 5'd0;

    // Reset value with requests and halt applied, then first cycle after release.
    step("reset", 0, mk(5'b00001, 5'h1F, 2'b00, 5'h00, 5'h00, 5'h00, 8'b00000000, 16'h0000), 1'b0);
    step("reset", 1, mk(5'b10000, 5'h00, 2'b00, 5'h00, 5'h00, 5'h00, 8'b00000000, 16'h0000), 1'b1);

    // Basic dispatch of bit 0, then no re-dispatch while ime=0.
    tbl[0]  = mk(5'b00000, 5'h00, 2'b01, 5'h01, 5'h00, 5'h00, 8'b00000000, 16'h0000);
    tbl[1]  = mk(5'b10010, 5'h00, 2'b00, 5'h00, 5'h00, 5'h01, 8'b00000000, 16'h0000);
    tbl[2]  = mk(5'b00000, 5'h01, 2'b00, 5'h00, 5'h00, 5'h01, 8'b10000000, 16'h0000);
    tbl[3]  = mk(5'b10000, 5'h00, 2'b00, 5'h00, 5'h01, 5'h01, 8'b10100000, 16'h0000);
    tbl[4]  = mk(5'b00000, 5'h00, 2'b00, 5'h00, 5'h01, 5'h01, 8'b00110000, 16'h0000);
    tbl[5]  = mk(5'b00000, 5'h00, 2'b00, 5'h00, 5'h01, 5'h01, 8'b00111000, 16'h0000);
    tbl[6]  = mk(5'b00000, 5'h00, 2'b00, 5'h00, 5'h01, 5'h01, 8'b00111100, 16'h0000);
    tbl[7]  = mk(5'b00000, 5'h00, 2'b00, 5'h00, 5'h01, 5'h01, 8'b00110010, 16'h0000);
    tbl[8]  = mk(5'b00000, 5'h01, 2'b00, 5'h00, 5'h00, 5'h01, 8'b00000001, 16'h0040);
    tbl[9]  = mk(5'b10000, 5'h00, 2'b00, 5'h00, 5'h01, 5'h01, 8'b00000000, 16'h0040);
    // IE=1F, IF=14: bit 2 wins.
    tbl[10] = mk(5'b00000, 5'h00, 2'b01, 5'h1F, 5'h01, 5'h01, 8'b00000000, 16'h0040);
    tbl[11] = mk(5'b10010, 5'h00, 2'b10, 5'h14, 5'h01, 5'h1F, 8'b00000000, 16'h0040);
    tbl[12] = mk(5'b10000, 5'h00, 2'b00, 5'h00, 5'h14, 5'h1F, 8'b10100000, 16'h0040);
    tbl[13] = mk(5'b00000, 5'h00, 2'b00, 5'h00, 5'h14, 5'h1F, 8'b00110000, 16'h0040);
    tbl[14] = mk(5'b00000, 5'h00, 2'b00, 5'h00, 5'h14, 5'h1F, 8'b00111000, 16'h0040);
    tbl[15] = mk(5'b00000, 5'h00, 2'b00, 5'h00, 5'h14, 5'h1F, 8'b00111100, 16'h0040);
    tbl[16] = mk(5'b00000, 5'h00, 2'b00, 5'h00, 5'h14, 5'h1F, 8'b00110010, 16'h0040);
    tbl[17] = mk(5'b00000, 5'h00, 2'b00, 5'h00, 5'h10, 5'h1F, 8'b00000001, 16'h0050);
    // EI delay: no dispatch at the EI boundary, dispatch at the next one.
    tbl[18] = mk(5'b11000, 5'h00, 2'b00, 5'h00, 5'h10, 5'h1F, 8'b00000000, 16'h0050);
    tbl[19] = mk(5'b00000, 5'h00, 2'b00, 5'h00, 5'h10, 5'h1F, 8'b00000000, 16'h0050);
    tbl[20] = mk(5'b10000, 5'h00, 2'b00, 5'h00, 5'h10, 5'h1F, 8'b00100000, 16'h0050);
    tbl[21] = mk(5'b00000, 5'h00, 2'b00, 5'h00, 5'h10, 5'h1F, 8'b00110000, 16'h0050);
    tbl[22] = mk(5'b00000, 5'h00, 2'b00, 5'h00, 5'h10, 5'h1F, 8'b00111000, 16'h0050);
    tbl[23] = mk(5'b00000, 5'h00, 2'b00, 5'h00, 5'h10, 5'h1F, 8'b00111100, 16'h0050);
    tbl[24] = mk(5'b00000, 5'h00, 2'b00, 5'h00, 5'h10, 5'h1F, 8'b00110010, 16'h0050);
    tbl[25] = mk(5'b00000, 5'h00, 2'b00, 5'h00, 5'h00, 5'h1F, 8'b00000001, 16'h0060);
    // EI then DI at the following boundary: no dispatch, ime stays 0.
    tbl[26] = mk(5'b11000, 5'h10, 2'b00, 5'h00, 5'h00, 5'h1F, 8'b00000000, 16'h0060);
    tbl[27] = mk(5'b10100, 5'h00, 2'b00, 5'h00, 5'h10, 5'h1F, 8'b00000000, 16'h0060);
    tbl[28] = mk(5'b10000, 5'h00, 2'b00, 5'h00, 5'h10, 5'h1F, 8'b00000000, 16'h0060);
    // Back-to-back EI keeps the delay armed; a request in D_PCL keeps IF[4] set.
    tbl[29] = mk(5'b11000, 5'h00, 2'b00, 5'h00, 5'h10, 5'h1F, 8'b00000000, 16'h0060);
    tbl[30] = mk(5'b11000, 5'h00, 2'b00, 5'h00, 5'h10, 5'h1F, 8'b00000000, 16'h0060);
    tbl[31] = mk(5'b10000, 5'h00, 2'b00, 5'h00, 5'h10, 5'h1F, 8'b00100000, 16'h0060);
    tbl[32] = mk(5'b00000, 5'h00, 2'b00, 5'h00, 5'h10, 5'h1F, 8'b00110000, 16'h0060);
    tbl[33] = mk(5'b00000, 5'h00, 2'b00, 5'h00, 5'h10, 5'h1F, 8'b00111000, 16'h0060);
    tbl[34] = mk(5'b00000, 5'h00, 2'b00, 5'h00, 5'h10, 5'h1F, 8'b00111100, 16'h0060);
    tbl[35] = mk(5'b00000, 5'h10, 2'b00, 5'h00, 5'h10, 5'h1F, 8'b00110010, 16'h0060);
    tbl[36] = mk(5'b00000, 5'h00, 2'b00, 5'h00, 5'h10, 5'h1F, 8'b00000001, 16'h0060);
    // Halted with ime=0: a single wake pulse, no dispatch, IF[2] kept.
    tbl[37] = mk(5'b00000, 5'h00, 2'b10, 5'h00, 5'h10, 5'h1F, 8'b00000000, 16'h0060);
    tbl[38] = mk(5'b00000, 5'h00, 2'b01, 5'h04, 5'h00, 5'h1F, 8'b00000000, 16'h0060);
    tbl[39] = mk(5'b00001, 5'h00, 2'b00, 5'h00, 5'h00, 5'h04, 8'b00000000, 16'h0060);
    tbl[40] = mk(5'b00001, 5'h04, 2'b00, 5'h00, 5'h00, 5'h04, 8'b00000000, 16'h0060);
    tbl[41] = mk(5'b00001, 5'h00, 2'b00, 5'h00, 5'h04, 5'h04, 8'b01000000, 16'h0060);
    tbl[42] = mk(5'b00001, 5'h00, 2'b00, 5'h00, 5'h04, 5'h04, 8'b00000000, 16'h0060);
    tbl[43] = mk(5'b10001, 5'h00, 2'b00, 5'h00, 5'h04, 5'h04, 8'b00000000, 16'h0060);
    // Request coinciding with an IF write of zero survives.
    tbl[44] = mk(5'b00000, 5'h02, 2'b10, 5'h00, 5'h04, 5'h04, 8'b00000000, 16'h0060);
    tbl[45] = mk(5'b00000, 5'h00, 2'b00, 5'h00, 5'h02, 5'h04, 8'b00000000, 16'h0060);
    // Dispatch cancelled by clearing IE in D_SPDEC: vector 0, IF untouched.
    tbl[46] = mk(5'b10010, 5'h00, 2'b01, 5'h02, 5'h02, 5'h04, 8'b00000000, 16'h0060);
    tbl[47] = mk(5'b10000, 5'h00, 2'b00, 5'h00, 5'h02, 5'h02, 8'b10100000, 16'h0060);
    tbl[48] = mk(5'b00000, 5'h00, 2'b00, 5'h00, 5'h02, 5'h02, 8'b00110000, 16'h0060);
    tbl[49] = mk(5'b00000, 5'h00, 2'b01, 5'h00, 5'h02, 5'h02, 8'b00111000, 16'h0060);
    tbl[50] = mk(5'b00000, 5'h00, 2'b00, 5'h00, 5'h02, 5'h00, 8'b00111100, 16'h0060);
    tbl[51] = mk(5'b00000, 5'h00, 2'b00, 5'h00, 5'h02, 5'h00, 8'b00110010, 16'h0060);
    tbl[52] = mk(5'b00000, 5'h00, 2'b00, 5'h00, 5'h02, 5'h00, 8'b00000001, 16'h0000);

    for (int i = 0; i < 53; i++) step("tbl", i, tbl[i], 1'b1);

    // Complete a bit-1 dispatch, start another, and assert reset in D_PCH.
    step("rst_mid", 0,  mk(5'b10010, 5'h00, 2'b01, 5'h02, 5'h02, 5'h00, 8'b00000000, 16'h0000), 1'b1);
    step("rst_mid", 1,  mk(5'b10000, 5'h00, 2'b00, 5'h00, 5'h02, 5'h02, 8'b10100000, 16'h0000), 1'b1);
    step("rst_mid", 2,  mk(5'b00000, 5'h00, 2'b00, 5'h00, 5'h02, 5'h02, 8'b00110000, 16'h0000), 1'b1);
    step("rst_mid", 3,  mk(5'b00000, 5'h00, 2'b00, 5'h00, 5'h02, 5'h02, 8'b00111000, 16'h0000), 1'b1);
    step("rst_mid", 4,  mk(5'b00000, 5'h00, 2'b00, 5'h00, 5'h02, 5'h02, 8'b00111100, 16'h0000), 1'b1);
    step("rst_mid", 5,  mk(5'b00000, 5'h00, 2'b00, 5'h00, 5'h02, 5'h02, 8'b00110010, 16'h0000), 1'b1);
    step("rst_mid", 6,  mk(5'b00000, 5'h00, 2'b00, 5'h00, 5'h00, 5'h02, 8'b00000001, 16'h0048), 1'b1);
    step("rst_mid", 7,  mk(5'b10010, 5'h02, 2'b00, 5'h00, 5'h00, 5'h02, 8'b00000000, 16'h0048), 1'b1);
    step("rst_mid", 8,  mk(5'b10000, 5'h00, 2'b00, 5'h00, 5'h02, 5'h02, 8'b10100000, 16'h0048), 1'b1);
    step("rst_mid", 9,  mk(5'b00000, 5'h00, 2'b00, 5'h00, 5'h02, 5'h02, 8'b00110000, 16'h0048), 1'b1);
    step("rst_mid", 10, mk(5'b00000, 5'h00, 2'b00, 5'h00, 5'h02, 5'h02, 8'b00111000, 16'h0048), 1'b1);
    step("rst_mid", 11, mk(5'b00000, 5'h01, 2'b00, 5'h00, 5'h00, 5'h00, 8'b00000000, 16'h0000), 1'b0);
    step("rst_mid", 12, mk(5'b10000, 5'h00, 2'b00, 5'h00, 5'h00, 5'h00, 8'b00000000, 16'h0000), 1'b1);
    step("rst_mid", 13, mk(5'b00000, 5'h00, 2'b00, 5'h00, 5'h00, 5'h00, 8'b00000000, 16'h0000), 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
